mem_wb_buf: RTL and testbench
=============================

// Module: mem_wb_buf
// PURPOSE
//  Pipeline boundary between the MEM stage and the write-back/regfile port.
//  Registers the MEM result {wd, wreg, wdata, pc} into a 2-entry skid buffer with valid/ready handshakes on both sides.
//  The MEM stage is never blocked by a single-cycle write-back stall.
//  Provides a combinational forwarding lookup over buffered results so that ID/EX can bypass the pending write-back.
// PARAMETERS
//  DATA_W  32  width of wdata / pc (matches `RegBus)
//  ADDR_W  5   width of destination register address (matches `RegAddrBus)
// PORTS
//  clk           in   1       single clock domain, all state on posedge
//  rst           in   1       synchronous, active-low reset (asserted when 0)
//  flush         in   1       pipeline flush (exception/branch redirect); drops all buffered entries
//  mem_valid_i   in   1       MEM result valid this cycle
//  mem_ready_o   out  1       buffer can accept a MEM result
//  wd_i          in   ADDR_W  destination register from MEM
//  wreg_i        in   1       write-enable from MEM
//  wdata_i       in   DATA_W  write data from MEM
//  pc_i          in   DATA_W  PC of the instruction (debug trace)
//  wb_valid_o    out  1       head entry valid toward write-back
//  wb_ready_i    in   1       write-back/regfile accepts head entry
//  wb_wd_o       out  ADDR_W  head destination register
//  wb_wreg_o     out  1       head write-enable
//  wb_wdata_o    out  DATA_W  head write data
//  wb_pc_o       out  DATA_W  head PC
//  fwd_raddr_i   in   ADDR_W  register address being looked up by ID/EX
//  fwd_hit_o     out  1       a buffered entry writes fwd_raddr_i
//  fwd_data_o    out  DATA_W  data of the youngest matching entry (0 on miss)
// BEHAVIOUR
//  - State: EMPTY (0 entries), ONE (head only), FULL (head + skid). Entries: head, skid.
//  - push = mem_valid_i & mem_ready_o; pop = wb_valid_o & wb_ready_i.
//  - mem_ready_o = (state != FULL), derived from registered state, no path from wb_ready_i.
//  - wb_valid_o = (state != EMPTY); wb_* always show the head entry, zero when EMPTY.
//  - Latency: a push in cycle N is visible on wb_* in cycle N+1; no same-cycle bypass.
//  - Transitions:
//    - EMPTY + push -> ONE (head <= input).
//    - ONE + push & !pop -> FULL (skid <= input).
//    - ONE + push & pop -> ONE (head <= input).
//    - ONE + pop & !push -> EMPTY.
//    - FULL + pop -> ONE (head <= skid). Push is impossible while FULL.
//    - All other cases: hold state and entries.
//  - Entries with wreg=0 still occupy a slot and are presented to write-back (keeps the trace in order).
//  - flush=1: next state EMPTY, both entries cleared. Flush overrides any same-cycle push and pop.
//    - A pop handshake in the flush cycle still counts as consumed by write-back.
//  - Reset (rst=0 at posedge): state EMPTY, entries zeroed (wd=`NOPRegAddr, wreg=`WriteDisable, data/pc=`ZeroWord).
//    - Outputs then: mem_ready_o=1, wb_valid_o=0, wb_*=0, fwd_hit_o=0, fwd_data_o=0.
//    - Reset mid-transfer discards all entries; no partial state survives.
//  - Forwarding, combinational:
//    - Skid (younger) is checked before head.
//    - An entry matches iff valid & wreg & wd==fwd_raddr_i & fwd_raddr_i!=0.
//    - fwd_raddr_i==0 never hits.
//    - fwd_data_o=0 on miss.
//    - Flush and reset affect forwarding only through cleared state.
// STRUCTURE
//  - Shared defines header: `RegBus, `RegAddrBus, `NOPRegAddr, `ZeroWord, `WriteDisable, plus the state encoding
//    MWB_EMPTY=2'd0, MWB_ONE=2'd1, MWB_FULL=2'd2 (unused code 2'd3 is treated as EMPTY).
//  - One natural sub-module: mwb_entry (valid-less register holding {wd, wreg, wdata, pc} with load and clear).
//    It is instantiated twice (head, skid); the FSM and forwarding mux stay in mem_wb_buf.
// TESTING
//  1. Reset: rst=0 for 2 cycles, then 1.
//     -> mem_ready_o=1, wb_valid_o=0, wb_wd_o=0, fwd_hit_o=0 throughout.
//  2. Streaming with wb_ready_i=1: push wd=3 wdata=0x11, then wd=4 wdata=0x22 back-to-back.
//     -> wb_* show 3/0x11 at N+1 and 4/0x22 at N+2; mem_ready_o stays 1.
//  3. Stall: wb_ready_i=0, push wd=5/0xA, then wd=6/0xB.
//     -> state FULL, mem_ready_o=0; a third push is held off.
//     -> wb_ready_i=1 drains 5/0xA, then 6/0xB, in order.
//  4. Forwarding: FULL with head wd=7/0x1, skid wd=7/0x2, fwd_raddr_i=7.
//     -> fwd_hit_o=1, fwd_data_o=0x2.
//     -> fwd_raddr_i=0 -> hit=0. An entry with wreg=0 and wd=7 alone -> hit=0.
//  5. Flush: FULL with a push offered and flush=1.
//     -> next cycle wb_valid_o=0, mem_ready_o=1; the offered entry never appears on wb_*.
//  6. Mid-stream reset: rst=0 while FULL.
//     -> next cycle all outputs at reset values; the first push after release appears alone on wb_*.

Source files
------------

// File: rtl/mem_wb_buf_pkg.sv
// Shared definitions for the MEM -> write-back boundary buffer.
//  - Bus widths matching the core's register-file data and address buses.
//  - Reset/empty values for a buffered entry.
//  - Occupancy state encoding of the 2-entry skid buffer.
package mem_wb_buf_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
  localparam logic [REG_BUS_W-1:0]  ZERO_WORD     = '0;
  localparam logic                  WRITE_DISABLE = 1'b0;

  // Code 2'd3 is never produced; the FSM treats it exactly like EMPTY.
  typedef enum logic [1:0] {
    MWB_EMPTY = 2'd0,
    MWB_ONE   = 2'd1,
    MWB_FULL  = 2'd2,
    MWB_RSVD  = 2'd3
  } mwb_state_e;

endpackage

// File: rtl/mwb_entry.sv
// One buffered MEM result {wd, wreg, wdata, pc}.
// Holds no valid bit: occupancy is tracked by the owning FSM.
// Ports:
//  clk                      clock, state on posedge
//  clr                      synchronous clear to the empty value (wins over ld)
//  ld                       load the d-side fields
//  wd_d/wreg_d/wdata_d/pc_d  fields to load
//  wd_q/wreg_q/wdata_q/pc_q  stored fields
import mem_wb_buf_pkg::*;

module mwb_entry #(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ld,
  input  logic [ADDR_W-1:0] wd_d,
  input  logic              wreg_d,
  input  logic [DATA_W-1:0] wdata_d,
  input  logic [DATA_W-1:0] pc_d,
  output logic [ADDR_W-1:0] wd_q,
  output logic              wreg_q,
  output logic [DATA_W-1:0] wdata_q,
  output logic [DATA_W-1:0] pc_q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      wd_q    <= ADDR_W'(NOP_REG_ADDR);
      wreg_q  <= WRITE_DISABLE;
      wdata_q <= DATA_W'(ZERO_WORD);
      pc_q    <= DATA_W'(ZERO_WORD);
    end else if (ld) begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: rtl/mem_wb_buf.sv
// MEM -> write-back pipeline boundary: 2-entry skid buffer (head + skid).
// A single-cycle write-back stall never blocks MEM, because the skid slot
// absorbs the result MEM already committed to. Also offers a combinational
// forwarding lookup over the buffered results for ID/EX.
// Ports:
//  clk, rst (sync, active-low), flush (drops all buffered entries)
//  mem_valid_i/mem_ready_o + wd_i, wreg_i, wdata_i, pc_i : MEM side
//  wb_valid_o/wb_ready_i + wb_wd_o, wb_wreg_o, wb_wdata_o, wb_pc_o : write-back side (head)
//  fwd_raddr_i -> fwd_hit_o, fwd_data_o : bypass lookup, youngest match wins
import mem_wb_buf_pkg::*;

module mem_wb_buf #(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [DATA_W-1:0] wb_pc_o,
  input  logic [ADDR_W-1:0] fwd_raddr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o
);

  mwb_state_e        state_q, state_d;
  logic              head_vld, skid_vld;
  logic              push, pop;
  logic              head_ld, head_clr, head_from_skid;
  logic              skid_ld, skid_clr;

  logic [ADDR_W-1:0] head_wd,    skid_wd,    head_wd_d;
  logic              head_wreg,  skid_wreg,  head_wreg_d;
  logic [DATA_W-1:0] head_wdata, skid_wdata, head_wdata_d;
  logic [DATA_W-1:0] head_pc,    skid_pc,    head_pc_d;

  logic              head_hit, skid_hit;

  function automatic logic entry_hit(input logic              vld,
                                     input logic              wreg,
                                     input logic [ADDR_W-1:0] wd,
                                     input logic [ADDR_W-1:0] raddr);
    // Register 0 is hardwired; never bypass it.
    return vld & wreg & (wd == raddr) & (raddr != '0);
  endfunction

  // Occupancy decode: the unused code behaves like EMPTY.
  assign head_vld = (state_q == MWB_ONE) || (state_q == MWB_FULL);
  assign skid_vld = (state_q == MWB_FULL);

  // Ready depends on registered state only, so no wb_ready_i -> mem_ready_o path.
  assign mem_ready_o = (state_q != MWB_FULL);
  assign wb_valid_o  = head_vld;

  assign push = mem_valid_i & mem_ready_o;
  assign pop  = wb_valid_o & wb_ready_i;

  // ---- next-state / entry control ----
  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    head_clr       = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;

    case (state_q)
      MWB_ONE: begin
        if (push && pop) begin
          head_ld = 1'b1;
        end else if (push) begin
          skid_ld = 1'b1;
          state_d = MWB_FULL;
        end else if (pop) begin
          head_clr = 1'b1;
          state_d  = MWB_EMPTY;
        end
      end
      MWB_FULL: begin
        if (pop) begin
          head_ld        = 1'b1;
          head_from_skid = 1'b1;
          skid_clr       = 1'b1;
          state_d        = MWB_ONE;
        end
      end
      default: begin
        // EMPTY, and the unused code recovers to EMPTY / ONE.
        if (push) begin
          head_ld = 1'b1;
          state_d = MWB_ONE;
        end else begin
          state_d = MWB_EMPTY;
        end
      end
    endcase

    // Flush drops everything, overriding any push or pop this cycle.
    if (flush) begin
      state_d        = MWB_EMPTY;
      head_ld        = 1'b0;
      head_from_skid = 1'b0;
      skid_ld        = 1'b0;
      head_clr       = 1'b1;
      skid_clr       = 1'b1;
    end
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MWB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Head is refilled either from MEM or by promoting the skid entry.
  assign head_wd_d    = head_from_skid ? skid_wd    : wd_i;
  assign head_wreg_d  = head_from_skid ? skid_wreg  : wreg_i;
  assign head_wdata_d = head_from_skid ? skid_wdata : wdata_i;
  assign head_pc_d    = head_from_skid ? skid_pc    : pc_i;

  // ---- entry storage ----
  mwb_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_head (
    .clk     (clk),
    .clr     (head_clr | ~rst),
    .ld      (head_ld),
    .wd_d    (head_wd_d),
    .wreg_d  (head_wreg_d),
    .wdata_d (head_wdata_d),
    .pc_d    (head_pc_d),
    .wd_q    (head_wd),
    .wreg_q  (head_wreg),
    .wdata_q (head_wdata),
    .pc_q    (head_pc)
  );

  mwb_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .clr     (skid_clr | ~rst),
    .ld      (skid_ld),
    .wd_d    (wd_i),
    .wreg_d  (wreg_i),
    .wdata_d (wdata_i),
    .pc_d    (pc_i),
    .wd_q    (skid_wd),
    .wreg_q  (skid_wreg),
    .wdata_q (skid_wdata),
    .pc_q    (skid_pc)
  );

  // ---- write-back outputs: head entry, forced to zero when empty ----
  assign wb_wd_o    = head_vld ? head_wd    : '0;
  assign wb_wreg_o  = head_vld ? head_wreg  : 1'b0;
  assign wb_wdata_o = head_vld ? head_wdata : '0;
  assign wb_pc_o    = head_vld ? head_pc    : '0;

  // ---- forwarding: skid is younger than head, so it is checked first ----
  assign skid_hit  = entry_hit(skid_vld, skid_wreg, skid_wd, fwd_raddr_i);
  assign head_hit  = entry_hit(head_vld, head_wreg, head_wd, fwd_raddr_i);
  assign fwd_hit_o = skid_hit | head_hit;

  always_comb begin
    fwd_data_o = '0;
    if (skid_hit) begin
      fwd_data_o = skid_wdata;
    end else if (head_hit) begin
      fwd_data_o = head_wdata;
    end
  end

endmodule

// File: tb/tb_mem_wb_buf.sv
module tb_mem_wb_buf;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              mem_valid_i;
  logic              mem_ready_o;
  logic [ADDR_W-1:0] wd_i;
  logic              wreg_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] pc_i;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [ADDR_W-1:0] wb_wd_o;
  logic              wb_wreg_o;
  logic [DATA_W-1:0] wb_wdata_o;
  logic [DATA_W-1:0] wb_pc_o;
  logic [ADDR_W-1:0] fwd_raddr_i;
  logic              fwd_hit_o;
  logic [DATA_W-1:0] fwd_data_o;

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] pc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  mem_wb_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .mem_valid_i (mem_valid_i),
    .mem_ready_o (mem_ready_o),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .pc_i        (pc_i),
    .wb_valid_o  (wb_valid_o),
    .wb_ready_i  (wb_ready_i),
    .wb_wd_o     (wb_wd_o),
    .wb_wreg_o   (wb_wreg_o),
    .wb_wdata_o  (wb_wdata_o),
    .wb_pc_o     (wb_pc_o),
    .fwd_raddr_i (fwd_raddr_i),
    .fwd_hit_o   (fwd_hit_o),
    .fwd_data_o  (fwd_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one MEM result; mem_valid_i stays high so pushes can be back-to-back.
  task automatic push(input logic [ADDR_W-1:0] wd, input logic wreg,
                      input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] pc);
    int n = 0;
    mem_valid_i = 1'b1;
    wd_i = wd; wreg_i = wreg; wdata_i = data; pc_i = pc;
    #0;
    while (!mem_ready_o && n < 20) begin
      step();
      n++;
    end
    if (n == 20) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: mem_ready_o stayed 0 for wd=%0d", wd);
    end else begin
      sb.push_back('{wd: wd, wreg: wreg, wdata: data, pc: pc});
      step();
    end
  endtask

  task automatic idle();
    mem_valid_i = 1'b0;
    wd_i = '0; wreg_i = 1'b0; wdata_i = '0; pc_i = '0;
  endtask

  task automatic lookup(input logic [ADDR_W-1:0] ra, input string name,
                        input logic exp_hit, input logic [DATA_W-1:0] exp_data);
    fwd_raddr_i = ra;
    #1;
    chk({name, "_hit"}, DATA_W'(fwd_hit_o), DATA_W'(exp_hit));
    chk({name, "_data"}, fwd_data_o, exp_data);
  endtask

  // Monitor: every write-back handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && wb_valid_o && wb_ready_i) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wb_unexpected: got wd=%0d wdata=0x%0h expected nothing", wb_wd_o, wb_wdata_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_wd", DATA_W'(wb_wd_o), DATA_W'(e.wd));
        chk("wb_wreg", DATA_W'(wb_wreg_o), DATA_W'(e.wreg));
        chk("wb_wdata", wb_wdata_o, e.wdata);
        chk("wb_pc", wb_pc_o, e.pc);
      end
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; wb_ready_i = 1'b0; fwd_raddr_i = 5'd3;
    idle();

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_mem_ready", DATA_W'(mem_ready_o), 1);
      chk("rst_wb_valid", DATA_W'(wb_valid_o), 0);
      chk("rst_wb_wd", DATA_W'(wb_wd_o), 0);
      chk("rst_fwd_hit", DATA_W'(fwd_hit_o), 0);
    end
    rst = 1'b1;
    step();

    // Streaming with write-back always ready
    wb_ready_i = 1'b1;
    push(5'd3, 1'b1, 32'h11, 32'h100);
    chk("str_valid1", DATA_W'(wb_valid_o), 1);
    chk("str_wd1", DATA_W'(wb_wd_o), 3);
    chk("str_data1", wb_wdata_o, 32'h11);
    push(5'd4, 1'b1, 32'h22, 32'h104);
    chk("str_wd2", DATA_W'(wb_wd_o), 4);
    chk("str_data2", wb_wdata_o, 32'h22);
    chk("str_ready", DATA_W'(mem_ready_o), 1);
    idle();
    step();
    chk("str_drained", DATA_W'(wb_valid_o), 0);

    // Stall: fill both slots, third offer held off
    wb_ready_i = 1'b0;
    push(5'd5, 1'b1, 32'hA, 32'h200);
    push(5'd6, 1'b1, 32'hB, 32'h204);
    mem_valid_i = 1'b1; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hC; pc_i = 32'h208;
    #1;
    chk("stall_ready", DATA_W'(mem_ready_o), 0);
    chk("stall_head", DATA_W'(wb_wd_o), 5);
    step();
    step();
    chk("stall_ready_hold", DATA_W'(mem_ready_o), 0);
    idle();
    wb_ready_i = 1'b1;
    step();
    step();
    chk("stall_drained", DATA_W'(wb_valid_o), 0);
    wb_ready_i = 1'b0;

    // Forwarding: youngest match wins
    push(5'd7, 1'b1, 32'h1, 32'h300);
    push(5'd7, 1'b1, 32'h2, 32'h304);
    idle();
    lookup(5'd7, "fwd_skid", 1'b1, 32'h2);
    lookup(5'd0, "fwd_r0", 1'b0, 32'h0);
    lookup(5'd5, "fwd_miss", 1'b0, 32'h0);
    wb_ready_i = 1'b1;
    step();
    step();
    wb_ready_i = 1'b0;
    push(5'd7, 1'b0, 32'h33, 32'h308);
    idle();
    lookup(5'd7, "fwd_nowreg", 1'b0, 32'h0);
    chk("nowreg_presented", DATA_W'(wb_valid_o), 1);
    push(5'd8, 1'b1, 32'h44, 32'h30C);
    idle();
    lookup(5'd8, "fwd_skid2", 1'b1, 32'h44);
    wb_ready_i = 1'b1;
    step();
    lookup(5'd8, "fwd_head", 1'b1, 32'h44);
    step();
    wb_ready_i = 1'b0;

    // Flush while FULL with a push offered
    push(5'd1, 1'b1, 32'h55, 32'h400);
    push(5'd2, 1'b1, 32'h66, 32'h404);
    flush = 1'b1;
    mem_valid_i = 1'b1; wd_i = 5'd31; wreg_i = 1'b1; wdata_i = 32'hDEAD; pc_i = 32'h408;
    step();
    flush = 1'b0;
    idle();
    sb.delete();
    chk("flush_valid", DATA_W'(wb_valid_o), 0);
    chk("flush_ready", DATA_W'(mem_ready_o), 1);
    lookup(5'd1, "flush_fwd", 1'b0, 32'h0);
    // Flush overrides an accepted-looking push in ONE
    push(5'd1, 1'b1, 32'h77, 32'h500);
    flush = 1'b1;
    mem_valid_i = 1'b1; wd_i = 5'd30; wreg_i = 1'b1; wdata_i = 32'hBEEF; pc_i = 32'h504;
    step();
    flush = 1'b0;
    idle();
    sb.delete();
    chk("flush_push_valid", DATA_W'(wb_valid_o), 0);
    wb_ready_i = 1'b1;
    step();
    step();
    wb_ready_i = 1'b0;

    // Reset while FULL
    push(5'd10, 1'b1, 32'h88, 32'h600);
    push(5'd11, 1'b1, 32'h99, 32'h604);
    idle();
    rst = 1'b0;
    step();
    sb.delete();
    fwd_raddr_i = 5'd10;
    #1;
    chk("mrst_ready", DATA_W'(mem_ready_o), 1);
    chk("mrst_valid", DATA_W'(wb_valid_o), 0);
    chk("mrst_wd", DATA_W'(wb_wd_o), 0);
    chk("mrst_wdata", wb_wdata_o, 0);
    chk("mrst_fwd_hit", DATA_W'(fwd_hit_o), 0);
    chk("mrst_fwd_data", fwd_data_o, 0);
    rst = 1'b1;
    step();
    wb_ready_i = 1'b1;
    push(5'd12, 1'b1, 32'hAB, 32'h700);
    idle();
    chk("post_rst_head", DATA_W'(wb_wd_o), 12);
    step();
    chk("post_rst_alone", DATA_W'(wb_valid_o), 0);
    step();

    chk("sb_empty", DATA_W'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
